// File: rtl/scoot_pkg.sv
// Shared types and constants for the scoot_world arena: FSM states, the default
// pellet column, and direction indices into the motor/sensor vectors.
package scoot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SENSE,
        WAIT,
        MOVE,
        DONE
    } state_e;

    localparam logic [9:0] DEF_ROW_PATTERN = 10'b0010101001;

    localparam int DIR_UP    = 0;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 3;

endpackage

// File: rtl/scoot_wrap_step.sv
// One-step modular coordinate update: +1 on inc, -1 on dec, hold when both or neither,
// wrapping N-1 -> 0 and 0 -> N-1.
module scoot_wrap_step #(
    parameter int N = 10,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [W-1:0] coord,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] next
);

    always_comb begin
        next = coord;
        if (inc && !dec) begin
            next = (coord == W'(N - 1)) ? '0 : coord + 1'b1;
        end else if (dec && !inc) begin
            next = (coord == '0) ? W'(N - 1) : coord - 1'b1;
        end
    end

endmodule

// File: rtl/scoot_world.sv
// Toroidal pellet arena for scootBot: collect, sense neighbours, await motor, move.
// Optional SCOOT_WORLD_TRACE_EN prints the position and pickups at each COLLECT.
import scoot_pkg::*;

module scoot_world #(
    parameter int              WIDTH       = 10,
    parameter int              HEIGHT      = 10,
    parameter int              NUM_STEPS   = 100,
    parameter logic [HEIGHT-1:0] ROW_PATTERN = DEF_ROW_PATTERN,
    parameter int              START_X     = WIDTH / 2,
    parameter int              START_Y     = HEIGHT / 2
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 mUp,
    input  logic                                 mRight,
    input  logic                                 mDown,
    input  logic                                 mLeft,
    input  logic                                 motor_valid,
    output logic                                 lUp,
    output logic                                 lRight,
    output logic                                 lDown,
    output logic                                 lLeft,
    output logic                                 sense_valid,
    output logic [$clog2(WIDTH)-1:0]             pos_x,
    output logic [$clog2(HEIGHT)-1:0]            pos_y,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0]    score,
    output logic [$clog2(NUM_STEPS+1)-1:0]       step_count,
    output logic                                 busy,
    output logic                                 done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int SW = $clog2(WIDTH*HEIGHT+1);
    localparam int CW = $clog2(NUM_STEPS+1);

    state_e                          state_q, state_d;
    logic [WIDTH-1:0][HEIGHT-1:0]    grid_q, grid_d;
    logic [XW-1:0]                   x_q, x_d;
    logic [YW-1:0]                   y_q, y_d;
    logic [SW-1:0]                   score_q, score_d;
    logic [CW-1:0]                   step_q, step_d;
    logic [3:0]                      sens_q, sens_d;
    logic [3:0]                      motor_q, motor_d;

    logic [XW-1:0] x_mv, x_p1, x_m1;
    logic [YW-1:0] y_mv, y_p1, y_m1;
    logic [CW-1:0] step_inc;
    logic          start_run;

    // Same wrap primitive produces both the move target and the four neighbour indices.
    scoot_wrap_step #(.N(WIDTH))  u_x_move (.coord(x_q), .inc(motor_q[DIR_RIGHT]), .dec(motor_q[DIR_LEFT]), .next(x_mv));
    scoot_wrap_step #(.N(HEIGHT)) u_y_move (.coord(y_q), .inc(motor_q[DIR_UP]),    .dec(motor_q[DIR_DOWN]), .next(y_mv));
    scoot_wrap_step #(.N(WIDTH))  u_x_p1   (.coord(x_q), .inc(1'b1), .dec(1'b0), .next(x_p1));
    scoot_wrap_step #(.N(WIDTH))  u_x_m1   (.coord(x_q), .inc(1'b0), .dec(1'b1), .next(x_m1));
    scoot_wrap_step #(.N(HEIGHT)) u_y_p1   (.coord(y_q), .inc(1'b1), .dec(1'b0), .next(y_p1));
    scoot_wrap_step #(.N(HEIGHT)) u_y_m1   (.coord(y_q), .inc(1'b0), .dec(1'b1), .next(y_m1));

    assign start_run = start && (state_q == IDLE || state_q == DONE);
    assign step_inc  = step_q + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grid_q  <= '0;
            x_q     <= XW'(START_X);
            y_q     <= YW'(START_Y);
            score_q <= '0;
            step_q  <= '0;
            sens_q  <= '0;
            motor_q <= '0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            score_q <= score_d;
            step_q  <= step_d;
            sens_q  <= sens_d;
            motor_q <= motor_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_run) state_d = COLLECT;
            COLLECT:    state_d = SENSE;
            SENSE:      state_d = WAIT;
            WAIT:       if (motor_valid) state_d = MOVE;
            MOVE:       state_d = (step_inc == CW'(NUM_STEPS)) ? DONE : COLLECT;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        grid_d  = grid_q;
        x_d     = x_q;
        y_d     = y_q;
        score_d = score_q;
        step_d  = step_q;
        sens_d  = sens_q;
        motor_d = motor_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_run) begin
                    for (int i = 0; i < WIDTH; i++) grid_d[i] = ROW_PATTERN;
                    x_d     = XW'(START_X);
                    y_d     = YW'(START_Y);
                    score_d = '0;
                    step_d  = '0;
                end
            end
            COLLECT: begin
                if (grid_q[x_q][y_q]) begin
                    grid_d[x_q][y_q] = 1'b0;
                    score_d          = score_q + 1'b1;
                end
            end
            SENSE: begin
                sens_d[DIR_UP]    = grid_q[x_q][y_p1];
                sens_d[DIR_DOWN]  = grid_q[x_q][y_m1];
                sens_d[DIR_RIGHT] = grid_q[x_p1][y_q];
                sens_d[DIR_LEFT]  = grid_q[x_m1][y_q];
            end
            WAIT: begin
                if (motor_valid) begin
                    motor_d[DIR_UP]    = mUp;
                    motor_d[DIR_RIGHT] = mRight;
                    motor_d[DIR_DOWN]  = mDown;
                    motor_d[DIR_LEFT]  = mLeft;
                end
            end
            MOVE: begin
                x_d    = x_mv;
                y_d    = y_mv;
                step_d = step_inc;
            end
            default: ;
        endcase
    end

    // Status flags decode straight from the state register.
    always_comb begin
        busy        = (state_q == COLLECT) || (state_q == SENSE) ||
                      (state_q == WAIT)    || (state_q == MOVE);
        done        = (state_q == DONE);
        sense_valid = (state_q == WAIT);
    end

    assign lUp        = sens_q[DIR_UP];
    assign lRight     = sens_q[DIR_RIGHT];
    assign lDown      = sens_q[DIR_DOWN];
    assign lLeft      = sens_q[DIR_LEFT];
    assign pos_x      = x_q;
    assign pos_y      = y_q;
    assign score      = score_q;
    assign step_count = step_q;

`ifdef SCOOT_WORLD_TRACE_EN
    always @(posedge clock) begin
        if (!reset && state_q == COLLECT) begin
            $display("x: %d\ty: %d", x_q, y_q);
            if (grid_q[x_q][y_q]) $display("Picked one up!");
        end
    end
`endif

endmodule
